// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   RESET_PC_DEFAULT  default fetch address after reset
//   INSTR_BYTES       size of one instruction word in bytes
//   fetch_entry_t     prefetch FIFO entry: {pc, instr}
//   align_word()      clears the byte-offset bits of an address
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~(INSTR_BYTES - 32'd1);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the fetch stage's bus signals.
//   imem_req / imem_addr / imem_rdata      instruction memory read port
//   redirect_valid / redirect_pc           branch/jump redirect from execute
//   instr_valid / instr / instr_pc / instr_ready   handshake towards decode
// modport master: the fetch unit; modport slave: memory, execute and decode.
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of fetch_entry_t.
//   clk, rst   clock and synchronous active-high reset
//   push       write wdata at the tail
//   pop        drop the head entry (ignored when empty)
//   flush      empty the FIFO; has priority over push and pop
//   wdata      entry to write
//   head       current head entry (stale contents when empty)
//   empty/full occupancy flags
//   count      number of valid entries (0..DEPTH)
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  fetch_entry_t    mem_d [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_pop;

  // Flags and head view, all taken directly from registered state.
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == CW'(DEPTH));
    count = count_q;
    head  = mem_q[rd_ptr_q];
  end

  // Next-state for storage, pointers and count; flush overrides everything.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop & ~empty;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_fifo_chk.sv
// fetch_fifo_chk: checker for the prefetch FIFO.
//   clk, rst   clock and synchronous active-high reset
//   push, pop  effective FIFO write / read strobes
//   flush      FIFO flush (wins over push)
//   full       FIFO full flag
// Occupancy accounting in the fetch unit must never push into a full FIFO
// unless the same cycle also frees an entry.
module fetch_fifo_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic flush,
  input logic full
);

  a_no_overflow : assert property (
    @(posedge clk) disable iff (rst) !(push && full && !pop && !flush)
  ) else $error("fetch_fifo_chk: push into full prefetch FIFO");

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
//   clk   clock, all state on posedge
//   rst   synchronous active-high reset
//   bus   fetch_unit_if.master:
//         imem_req/imem_addr out, imem_rdata in (data one cycle after req)
//         redirect_valid/redirect_pc in (taken branch/jump, low bits ignored)
//         instr_valid/instr/instr_pc out, instr_ready in (decode handshake)
// Owns the fetch PC, issues one word read per cycle while the prefetch FIFO
// has room, buffers returned words with their PC and hands them to decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  // One extra bit so count + inflight never overflows.
  localparam int CW = $clog2(DEPTH) + 2;

  logic [31:0]            fetch_pc_q, fetch_pc_d;
  logic [31:0]            req_pc_q, req_pc_d;
  logic                   inflight_q, inflight_d;
  logic                   discard_q, discard_d;

  logic                   issue;
  logic                   push;
  logic                   pop;
  logic [CW-1:0]          occupancy;
  fetch_entry_t           fifo_wdata;
  fetch_entry_t           fifo_head;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic [$clog2(DEPTH):0] fifo_count;

  // Issue decision and next-state for the fetch PC bookkeeping.
  always_comb begin
    pop = ~rst & ~fifo_empty & bus.instr_ready & ~bus.redirect_valid;
    // Slots already claimed, crediting the head leaving this cycle, so a
    // two-entry FIFO still streams one instruction per cycle.
    occupancy  = CW'(fifo_count) + CW'(inflight_q) - CW'(pop);
    issue      = ~rst & ~bus.redirect_valid & (occupancy < CW'(DEPTH));
    push       = inflight_q & ~discard_q;
    fifo_wdata = '{pc: req_pc_q, instr: bus.imem_rdata};

    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    discard_d  = 1'b0;
    if (bus.redirect_valid) begin
      fetch_pc_d = align_word(bus.redirect_pc);
      // A word still returning belongs to the old path.
      discard_d  = inflight_q;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + INSTR_BYTES;
      req_pc_d   = fetch_pc_q;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  // Fetch PC, request tracking and discard flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 32'h0000_0000;
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  // Bus outputs; everything is forced to zero while reset is asserted.
  always_comb begin
    bus.imem_req    = issue;
    bus.imem_addr   = rst ? 32'h0000_0000 : fetch_pc_q;
    bus.instr_valid = ~rst & ~fifo_empty;
    bus.instr       = rst ? 32'h0000_0000 : fifo_head.instr;
    bus.instr_pc    = rst ? 32'h0000_0000 : fifo_head.pc;
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .wdata (fifo_wdata),
    .head  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  fetch_fifo_chk u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .full  (fifo_full)
  );

endmodule
